// File: rtl/queue_uart_tx_if.sv
// Pop/data channel between the 8-entry byte queue and the UART transmitter.
//   len_in      : queue element count (0-8), driven by the queue
//   data_in     : queue's registered data_out, driven by the queue
//   dequeue_out : one-cycle pop request, driven by the transmitter
// master = queue side, slave = transmitter side.
interface queue_uart_tx_if;
    logic [3:0] len_in;
    logic [7:0] data_in;
    logic       dequeue_out;

    modport master (
        output len_in,
        output data_in,
        input  dequeue_out
    );

    modport slave (
        input  len_in,
        input  data_in,
        output dequeue_out
    );
endinterface

// File: rtl/queue_uart_tx.sv
// Queue-draining UART transmitter in the clk_10khz domain.
// Pops one byte at a time from the byte queue, captures it the cycle after the pop and
// sends start bit, 8 data bits LSB-first, optional even-parity bit and stop bit.
// Ports:
//   clk_10khz      : sole clock
//   reset          : synchronous, active-high reset
//   enable_in      : permits new pops; an in-flight frame always completes
//   q_if           : queue channel (len_in, data_in in; dequeue_out out)
//   tx_out         : serial line, idle high
//   busy_out       : high in every state except idle
//   sent_count_out : frames completed, modulo 256
// All outputs are registered.
module queue_uart_tx #(
    parameter int unsigned BIT_CYCLES = 4,
    parameter bit          PARITY_EN  = 1'b0
) (
    input  logic              clk_10khz,
    input  logic              reset,
    input  logic              enable_in,
    queue_uart_tx_if.slave    q_if,
    output logic              tx_out,
    output logic              busy_out,
    output logic [7:0]        sent_count_out
);

    localparam int unsigned   TimerW   = $clog2(BIT_CYCLES) + 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StWait,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e              state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                parity_q, parity_d;
    logic                dequeue_q, dequeue_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic [7:0]          sent_q, sent_d;
    logic                bit_end;

    assign bit_end = (timer_q == TimerLast);

    // Outputs are registered, so each output takes the value of the state being entered
    // at the same edge that enters it.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        dequeue_d = dequeue_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        sent_d    = sent_q;

        unique case (state_q)
            StIdle: begin
                if (enable_in && (q_if.len_in != 4'd0)) begin
                    state_d   = StPop;
                    dequeue_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            StPop: begin
                state_d   = StWait;
                dequeue_d = 1'b0;
            end
            StWait: begin
                // The queue updated data_out at the edge ending the pop cycle.
                shift_d  = q_if.data_in;
                parity_d = ^q_if.data_in;
                timer_d  = '0;
                tx_d     = 1'b0;
                state_d  = StStart;
            end
            StStart: begin
                if (bit_end) begin
                    timer_d = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = StData;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (bit_q == 3'd7) begin
                        if (PARITY_EN) begin
                            tx_d    = parity_q;
                            state_d = StParity;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = StStop;
                        end
                    end else begin
                        // shift_q[0] is the bit on the line; the next one sits at [1].
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StParity: begin
                if (bit_end) begin
                    timer_d = '0;
                    tx_d    = 1'b1;
                    state_d = StStop;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    timer_d = '0;
                    busy_d  = 1'b0;
                    sent_d  = sent_q + 8'd1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                dequeue_d = 1'b0;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_10khz) begin
        if (reset) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            dequeue_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            sent_q    <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            dequeue_q <= dequeue_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            sent_q    <= sent_d;
        end
    end

    assign q_if.dequeue_out = dequeue_q;
    assign tx_out           = tx_q;
    assign busy_out         = busy_q;
    assign sent_count_out   = sent_q;

endmodule

// File: doc/queue_uart_tx.md
Name: queue_uart_tx

Overview:
- Downstream consumer of the 8-entry byte queue, in the clk_10khz domain.
- Watches the queue fill level and pops one byte at a time with a single-cycle dequeue pulse.
- Captures the byte the queue presents one cycle after the pop and shifts it out as an asynchronous serial frame: start bit, 8 data bits LSB-first, optional parity bit, stop bit.
- Drains the queue back-to-back while enabled.

Parameters:
- BIT_CYCLES, 4: clk_10khz cycles per serial bit. Must be ≥1. Bit timer width is $clog2(BIT_CYCLES)+1.
- PARITY_EN, 0: 1 inserts an even-parity bit between data bit 7 and the stop bit.

Ports:
- clk_10khz  input  1  system clock, 10 kHz, sole clock.
- reset  input  1  synchronous, active-high reset.
- enable_in  input  1  permits new pops; an in-flight frame always completes.
- len_in  input  4  queue element count (0-8), driven from the queue's len_out.
- data_in  input  8  queue's registered data_out.
- dequeue_out  output  1  one-cycle pop request, driven to the queue's dequeue_in.
- tx_out  output  1  serial line, idle high.
- busy_out  output  1  high in every state except IDLE.
- sent_count_out  output  8  frames completed, modulo 256.

Behaviour:
- One clock: clk_10khz. Reset is synchronous, active-high.
- Reset values: dequeue_out=0, tx_out=1, busy_out=0, sent_count_out=0, state=IDLE, shift/bit/timer registers=0.
- Reset during any state: outputs take reset values at that edge; the in-flight byte is discarded. No further pop until IDLE sees a pop condition.
- All outputs are registered.
- States: IDLE, POP, WAIT, START, DATA, PARITY, STOP.
- IDLE:
  - Pop condition: enable_in=1 and len_in≠0. If true, go to POP. Otherwise stay.
  - len_in and enable_in are sampled only in IDLE.
- POP:
  - dequeue_out=1 for exactly this one cycle; then WAIT.
  - The queue samples dequeue at the edge ending POP and updates data_out.
- WAIT:
  - dequeue_out=0.
  - At the edge ending WAIT, capture data_in into the shift register and compute parity (XOR of the 8 bits). Go to START.
- START: tx_out=0 for BIT_CYCLES cycles.
- DATA:
  - Bits 0..7, LSB first, each held BIT_CYCLES cycles.
  - Bit index counts 0→7; after bit 7, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx_out = XOR of the data bits (even parity) for BIT_CYCLES cycles.
- STOP:
  - tx_out=1 for BIT_CYCLES cycles.
  - At the final edge: sent_count_out increments (255 wraps to 0) and the state returns to IDLE.
- Frame period in cycles, IDLE through end of STOP: 3 + (10+PARITY_EN)×BIT_CYCLES.
- Back-to-back frames always have exactly one IDLE cycle between them; line stays high during it.
- enable_in low mid-frame: current frame finishes normally; block then stays in IDLE.
- Underflow is impossible: a pop is issued only when len_in≠0, and at most one pop is outstanding.
- Simultaneous upstream enqueue: irrelevant to this block; len_in is re-read in the next IDLE.
- tx_out changes only at bit boundaries. No glitch between consecutive equal bits.

Test Plan:
- Reset: hold reset 3 cycles with enable_in=1, len_in=5 -> dequeue_out=0, tx_out=1, busy_out=0, sent_count_out=0 throughout. First dequeue_out pulse is 2 cycles after reset deasserts (one IDLE cycle, then POP).
- Empty queue: enable_in=1, len_in=0 for 50 cycles -> dequeue_out never high, tx_out=1, busy_out=0.
- Single byte (BIT_CYCLES=4, PARITY_EN=0): queue model holding 0xA5 -> one dequeue_out pulse, 1 cycle wide. tx_out sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1. busy_out high 42 cycles. sent_count_out=1. Queue model len returns to 0.
- Drain 3 bytes 0x01, 0x80, 0xFF -> dequeue pulses exactly 43 cycles apart. Frames match LSB-first encoding. sent_count_out=3. No fourth pop.
- Parity (PARITY_EN=1): byte 0x07 -> parity bit 1, byte 0x03 -> parity bit 0. Frame length 44 data-path cycles plus 3 overhead.
- Boundary events:
  - Drop enable_in during DATA bit 2 -> frame completes, no further pop.
  - Assert reset during DATA bit 5 -> tx_out=1 and busy_out=0 on the next edge.
  - Preload 255 completed frames, send one more -> sent_count_out wraps 255→0.
